// File: rtl/alu_pkg.sv
// Shared types and constants for the registered integer ALU.
// Every module of the ALU imports this package.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_XOR = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SUB = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL, SRL and SRA on operand A.
// Any opcode other than SRL or SRA selects a left shift.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH_DEFAULT,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  alu_op_e            op_i,
    output logic [WIDTH-1:0]   result_o
);

    always_comb begin
        result_o = a_i << shamt_i;
        case (op_i)
            ALU_SRL: result_o = a_i >> shamt_i;
            // Arithmetic shift replicates A's sign bit into the vacated positions.
            ALU_SRA: result_o = $unsigned($signed(a_i) >>> shamt_i);
            default: result_o = a_i << shamt_i;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered integer ALU: logic, add/sub and shift ops with a one-cycle latency.
// The result and zero flag only update on cycles where in_valid is high.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic [2:0]       alu_ctrl,
    output logic             out_valid,
    output logic [WIDTH-1:0] output_result,
    output logic             zero_flag
);

    localparam int SHAMT_W = $clog2(WIDTH);

    // Handshake: in_valid has no ready partner; every valid input is accepted
    // and shows up exactly one cycle later with out_valid high for one cycle.

    alu_op_e          op;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             valid_q;

    assign op = alu_op_e'(alu_ctrl);

    // One adder serves ADD and SUB: subtraction is A + ~B + 1.
    assign is_sub = (op == ALU_SUB);
    assign b_eff  = input_B ^ {WIDTH{is_sub}};
    assign sum    = input_A + b_eff + {{(WIDTH-1){1'b0}}, is_sub};

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .a_i      (input_A),
        .shamt_i  (input_B[SHAMT_W-1:0]),
        .op_i     (op),
        .result_o (shift_res)
    );

    always_comb begin
        result_d = '0;
        case (op)
            ALU_AND: result_d = input_A & input_B;
            ALU_OR:  result_d = input_A | input_B;
            ALU_XOR: result_d = input_A ^ input_B;
            ALU_ADD: result_d = sum;
            ALU_SUB: result_d = sum;
            ALU_SLL: result_d = shift_res;
            ALU_SRL: result_d = shift_res;
            ALU_SRA: result_d = shift_res;
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign out_valid     = valid_q;
    assign output_result = result_q;
    assign zero_flag     = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset/hold behaviour and
// randomized operations compared against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] input_A;
    logic [31:0] input_B;
    logic [2:0]  alu_ctrl;
    logic        out_valid;
    logic [31:0] output_result;
    logic        zero_flag;

    int n_vec;
    int n_err;

    logic [32:0] exp_q[$];
    logic [31:0] last_res;
    logic        last_zero;

    alu #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .input_A       (input_A),
        .input_B       (input_B),
        .alu_ctrl      (alu_ctrl),
        .out_valid     (out_valid),
        .output_result (output_result),
        .zero_flag     (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model built from plain integer arithmetic: shifts are
    // multiplication/division by powers of two, SUB adds 2^32 before wrapping.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned ua, ub, p, r, m;
        int sh;
        ua = 64'(a);
        ub = 64'(b);
        m  = 64'h1_0000_0000;
        sh = int'(b % 32);
        p  = 1;
        for (int i = 0; i < sh; i++) p = p * 2;
        case (op)
            3'd0: r = 64'(a & b);
            3'd1: r = 64'(a | b);
            3'd2: r = 64'(a ^ b);
            3'd3: r = (ua + ub) % m;
            3'd4: r = (ua + m - ub) % m;
            3'd5: r = (ua * p) % m;
            3'd6: r = ua / p;
            default: r = a[31] ? (m - 1) - (((m - 1) - ua) / p) : ua / p;
        endcase
        return {r == 0, r[31:0]};
    endfunction

    // Drive one valid op, let it register, and check it one cycle later.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [32:0] e;
        input_A  = a;
        input_B  = b;
        alu_ctrl = op;
        in_valid = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".res"}, output_result, e[31:0]);
        check({tag, ".zero"}, 32'(zero_flag), 32'(e[32]));
        last_res  = e[31:0];
        last_zero = e[32];
    endtask

    task automatic idle_check(input string tag);
        in_valid = 1'b0;
        input_A  = $urandom;
        input_B  = $urandom;
        alu_ctrl = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".res"}, output_result, last_res);
        check({tag, ".zero"}, 32'(zero_flag), 32'(last_zero));
    endtask

    task automatic directed(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res, input logic z);
        input_A  = a;
        input_B  = b;
        alu_ctrl = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".res"}, output_result, res);
        check({tag, ".zero"}, 32'(zero_flag), 32'(z));
        last_res  = res;
        last_zero = z;
    endtask

    localparam logic [31:0] TA = 32'hB2AE84E5;
    localparam logic [31:0] TB = 32'hBD46A1EA;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        input_A  = '0;
        input_B  = '0;
        alu_ctrl = '0;
        #12;
        check("rst.res", output_result, 32'd0);
        check("rst.zero", 32'(zero_flag), 32'd1);
        check("rst.valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("and", 3'd0, TA, TB, 32'hB00680E0, 1'b0);
        directed("or",  3'd1, TA, TB, 32'hBFEEA5EF, 1'b0);
        directed("xor", 3'd2, TA, TB, 32'h0FE8250F, 1'b0);
        directed("add", 3'd3, TA, TB, 32'h6FF526CF, 1'b0);
        directed("sub", 3'd4, TA, TB, 32'hF567E2FB, 1'b0);
        directed("sll", 3'd5, TA, 32'd10, 32'hBA139400, 1'b0);
        directed("srl", 3'd6, TA, 32'd10, 32'h002CABA1, 1'b0);
        directed("sra", 3'd7, TA, 32'd10, 32'hFFECABA1, 1'b0);
        directed("subz", 3'd4, 32'h12345678, 32'h12345678, 32'd0, 1'b1);
        directed("or1", 3'd1, 32'd1, 32'd0, 32'd1, 1'b0);
        // Upper bits of B must not affect the shift amount.
        directed("sra_hi", 3'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        directed("sll31", 3'd5, 32'h00000003, 32'h0000001F, 32'h80000000, 1'b0);
        directed("srl0", 3'd6, 32'hDEADBEEF, 32'hFFFFFFE0, 32'hDEADBEEF, 1'b0);
        idle_check("hold0");

        // Asynchronous reset mid-cycle with a valid op pending.
        input_A  = 32'h5;
        input_B  = 32'h3;
        alu_ctrl = 3'd3;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.res", output_result, 32'd0);
        check("arst.zero", 32'(zero_flag), 32'd1);
        check("arst.valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_res  = 32'd0;
        last_zero = 1'b1;
        idle_check("post_rst");

        for (int i = 0; i < 8; i++) begin
            issue("b2b", 3'(i), $urandom, $urandom);
        end
        idle_check("hold1");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 32'h0;
                2: a = {1'b1, a[30:0]};
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) idle_check("rnd_idle");
            else issue("rnd", 3'($urandom_range(0, 7)), a, b);
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
